// File: rtl/button_event_decoder.sv
// Turns the debounced button level into registered one-cycle event pulses
// (press, release, short, long, repeat) plus a running count of completed presses.
module button_event_decoder #(
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter int REPEAT_CYCLES     = 12_500_000,
  parameter int CNT_WIDTH         = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button_pressed,
  output logic       held,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       short_press,
  output logic       long_press,
  output logic       repeat_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    LONG  = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};
  localparam bit                   REPEAT_ON   = (REPEAT_CYCLES != 0);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 press_pulse_q, press_pulse_d;
  logic                 release_pulse_q, release_pulse_d;
  logic                 short_press_q, short_press_d;
  logic                 long_press_q, long_press_d;
  logic                 repeat_pulse_q, repeat_pulse_d;
  logic [7:0]           press_count_q, press_count_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    short_press_d   = 1'b0;
    long_press_d    = 1'b0;
    repeat_pulse_d  = 1'b0;
    press_count_d   = press_count_q;
    unique case (state_q)
      IDLE: begin
        if (button_pressed) begin
          state_d       = PRESS;
          press_pulse_d = 1'b1;
          cnt_d         = CNT_WIDTH'(1);
        end
      end
      PRESS: begin
        // A low sample always wins over the long threshold on the same edge.
        if (!button_pressed) begin
          state_d         = IDLE;
          release_pulse_d = 1'b1;
          short_press_d   = 1'b1;
          press_count_d   = press_count_q + 8'd1;
        end else if (cnt_q == LONG_LAST) begin
          state_d      = LONG;
          long_press_d = 1'b1;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      LONG: begin
        if (!button_pressed) begin
          state_d         = IDLE;
          release_pulse_d = 1'b1;
          press_count_d   = press_count_q + 8'd1;
        end else if (REPEAT_ON && (cnt_q == REPEAT_LAST)) begin
          repeat_pulse_d = 1'b1;
          cnt_d          = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      short_press_q   <= 1'b0;
      long_press_q    <= 1'b0;
      repeat_pulse_q  <= 1'b0;
      press_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      short_press_q   <= short_press_d;
      long_press_q    <= long_press_d;
      repeat_pulse_q  <= repeat_pulse_d;
      press_count_q   <= press_count_d;
    end
  end

  assign held          = (state_q != IDLE);
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign short_press   = short_press_q;
  assign long_press    = long_press_q;
  assign repeat_pulse  = repeat_pulse_q;
  assign press_count   = press_count_q;

endmodule
